segment_sequencer: RTL and testbench

//  Upstream control stage for the seven-segment VGA renderer. Synchronises and debounces ui_in,

---
 rtl/segment_sequencer_if.sv | 28 ++
 rtl/segment_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_segment_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/segment_sequencer_if.sv
// Handshake bundle between the segment sequencer and its neighbours:
// raw switches and vsync in, segment mask and frame bookkeeping out.
interface segment_sequencer_if;
    logic [7:0] ui_in;
    logic       vsync;
    logic [7:0] led;
    logic [9:0] frame_cnt;
    logic       frame_tick;
    logic       show;

    modport master (
        output ui_in,
        output vsync,
        input  led,
        input  frame_cnt,
        input  frame_tick,
        input  show
    );

    modport slave (
        input  ui_in,
        input  vsync,
        output led,
        output frame_cnt,
        output frame_tick,
        output show
    );
endinterface

// File: rtl/segment_sequencer.sv
// Control stage for the seven-segment renderer: synchronises and debounces the switches per frame,
// counts frames from vsync and selects between the boot countdown and the live switch pattern.
module segment_sequencer #(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned FRAMES_PER_STEP = 64,
    parameter int unsigned IDLE_FRAMES     = 600
) (
    input  logic                 clk,
    input  logic                 rst_n,
    segment_sequencer_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_COUNTDOWN = 1'b0,
        ST_LIVE      = 1'b1
    } state_t;

    localparam logic [3:0] DB_MAX     = 4'(DEBOUNCE_FRAMES);
    localparam logic [9:0] IDLE_MAX   = 10'(IDLE_FRAMES);
    localparam bit         IDLE_EN    = (IDLE_FRAMES != 0);
    localparam int         STEP_SHIFT = $clog2(FRAMES_PER_STEP);
    localparam logic [7:0] LED_RESET  = 8'h67;

    // Countdown frame table: digits 9..0, then three blinks of the dot.
    function automatic logic [7:0] countdown_seg(input logic [3:0] idx);
        logic [7:0] seg;
        case (idx)
            4'd0:    seg = 8'h67;
            4'd1:    seg = 8'h7F;
            4'd2:    seg = 8'h07;
            4'd3:    seg = 8'h7D;
            4'd4:    seg = 8'h6D;
            4'd5:    seg = 8'h66;
            4'd6:    seg = 8'h4F;
            4'd7:    seg = 8'h5B;
            4'd8:    seg = 8'h06;
            4'd9:    seg = 8'h3F;
            4'd10:   seg = 8'h80;
            4'd11:   seg = 8'h00;
            4'd12:   seg = 8'h80;
            4'd13:   seg = 8'h00;
            4'd14:   seg = 8'h80;
            4'd15:   seg = 8'h00;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    logic [7:0] ui_meta_r;
    logic [7:0] ui_sync_r;
    logic       vs_r;
    logic       frame_tick_r;
    logic [9:0] frame_cnt_r;
    logic [7:0] sample_r;
    logic [7:0] db_r;
    logic [3:0] stable_r;
    logic [9:0] idle_r;
    state_t     state_r;
    logic [7:0] led_r;
    logic       show_r;

    logic [9:0] frame_cnt_s;
    logic [7:0] sample_s;
    logic [7:0] db_s;
    logic [3:0] stable_s;
    logic [9:0] idle_s;
    state_t     state_s;
    logic [7:0] led_s;
    logic       show_s;

    // Next-state logic; everything except the tick detector holds between frame ticks.
    always_comb begin
        frame_cnt_s = frame_cnt_r;
        sample_s    = sample_r;
        db_s        = db_r;
        stable_s    = stable_r;
        idle_s      = idle_r;
        state_s     = state_r;
        led_s       = led_r;
        show_s      = show_r;

        if (frame_tick_r) begin
            frame_cnt_s = frame_cnt_r + 10'd1;
            sample_s    = ui_sync_r;

            if (ui_sync_r == sample_r) begin
                if (stable_r >= DB_MAX) begin
                    stable_s = DB_MAX;
                end else begin
                    stable_s = stable_r + 4'd1;
                end
            end else begin
                stable_s = 4'd1;
            end

            if (stable_s == DB_MAX) begin
                db_s = ui_sync_r;
            end else begin
                db_s = db_r;
            end

            case (state_r)
                ST_COUNTDOWN: begin
                    idle_s = 10'd0;
                    if (db_s != 8'd0) begin
                        state_s = ST_LIVE;
                    end else begin
                        state_s = ST_COUNTDOWN;
                    end
                end
                ST_LIVE: begin
                    if (db_s == 8'd0) begin
                        if (idle_r != 10'h3FF) begin
                            idle_s = idle_r + 10'd1;
                        end else begin
                            idle_s = idle_r;
                        end
                    end else begin
                        idle_s = 10'd0;
                    end
                    // A nonzero db_s always clears idle_s, so an accept beats a timeout here.
                    if (IDLE_EN && (idle_s == IDLE_MAX)) begin
                        state_s     = ST_COUNTDOWN;
                        frame_cnt_s = 10'd0;
                        idle_s      = 10'd0;
                    end else begin
                        state_s = ST_LIVE;
                    end
                end
                default: begin
                    state_s = ST_COUNTDOWN;
                    idle_s  = 10'd0;
                end
            endcase

            if (state_s == ST_LIVE) begin
                led_s = db_s;
            end else begin
                led_s = countdown_seg(4'(frame_cnt_s >> STEP_SHIFT));
            end
            show_s = (state_s == ST_LIVE);
        end else begin
            led_s  = led_r;
            show_s = show_r;
        end
    end

    // Synchroniser, vsync edge detector and all frame-rate state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_meta_r    <= 8'd0;
            ui_sync_r    <= 8'd0;
            vs_r         <= 1'b0;
            frame_tick_r <= 1'b0;
            frame_cnt_r  <= 10'd0;
            sample_r     <= 8'd0;
            db_r         <= 8'd0;
            stable_r     <= 4'd0;
            idle_r       <= 10'd0;
            state_r      <= ST_COUNTDOWN;
            led_r        <= LED_RESET;
            show_r       <= 1'b0;
        end else begin
            ui_meta_r    <= bus.ui_in;
            ui_sync_r    <= ui_meta_r;
            vs_r         <= bus.vsync;
            frame_tick_r <= bus.vsync & ~vs_r;
            frame_cnt_r  <= frame_cnt_s;
            sample_r     <= sample_s;
            db_r         <= db_s;
            stable_r     <= stable_s;
            idle_r       <= idle_s;
            state_r      <= state_s;
            led_r        <= led_s;
            show_r       <= show_s;
        end
    end

    assign bus.led        = led_r;
    assign bus.frame_cnt  = frame_cnt_r;
    assign bus.frame_tick = frame_tick_r;
    assign bus.show       = show_r;

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed bench for segment_sequencer: full countdown sweep, a vector table for
// debounce/live/idle behaviour, then vsync-hold and asynchronous-reset sequences.
module tb_segment_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    segment_sequencer_if bus_if ();

    segment_sequencer #(
        .DEBOUNCE_FRAMES (2),
        .FRAMES_PER_STEP (64),
        .IDLE_FRAMES     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [7:0] ui;
        logic [7:0] led;
        logic       show;
        logic [9:0] fc;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] seg_tab [16];
    int         chk_cnt  = 0;
    int         pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] ui, input logic [7:0] led, input logic show,
                           input logic [9:0] fc);
        vec_t v;
        v.ui = ui; v.led = led; v.show = show; v.fc = fc;
        vecs.push_back(v);
    endtask

    // One vsync pulse; returns on the negedge after the update edge.
    task automatic frame_pulse();
        @(negedge clk);
        bus_if.vsync = 1'b1;
        @(negedge clk);
        check("tick_high", {31'd0, bus_if.frame_tick}, 32'd1);
        bus_if.vsync = 1'b0;
        @(negedge clk);
        check("tick_low", {31'd0, bus_if.frame_tick}, 32'd0);
    endtask

    initial begin
        int ticks;
        seg_tab = '{8'h67, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B,
                    8'h06, 8'h3F, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00};
        bus_if.ui_in = 8'h00;
        bus_if.vsync = 1'b0;

        #12;
        check("rst_led",  {24'd0, bus_if.led},        32'h67);
        check("rst_fc",   {22'd0, bus_if.frame_cnt},  32'd0);
        check("rst_tick", {31'd0, bus_if.frame_tick}, 32'd0);
        check("rst_show", {31'd0, bus_if.show},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full countdown sweep including the 1023->0 wrap.
        for (int k = 1; k <= 1024; k++) begin
            int efc;
            frame_pulse();
            efc = k % 1024;
            check($sformatf("sweep%0d_led", k), {24'd0, bus_if.led}, {24'd0, seg_tab[(efc / 64) % 16]});
            check($sformatf("sweep%0d_fc", k), {22'd0, bus_if.frame_cnt}, efc);
            check($sformatf("sweep%0d_show", k), {31'd0, bus_if.show}, 32'd0);
        end

        // Glitch, debounce accept, live updates, accept racing a timeout, idle timeout.
        add_vec(8'h01, 8'h67, 1'b0, 10'd1);
        add_vec(8'h00, 8'h67, 1'b0, 10'd2);
        for (int f = 3; f <= 9; f++) add_vec(8'h00, 8'h67, 1'b0, 10'(f));
        add_vec(8'h3F, 8'h67, 1'b0, 10'd10);
        add_vec(8'h3F, 8'h3F, 1'b1, 10'd11);
        add_vec(8'h3F, 8'h3F, 1'b1, 10'd12);
        add_vec(8'h06, 8'h3F, 1'b1, 10'd13);
        add_vec(8'h06, 8'h06, 1'b1, 10'd14);
        add_vec(8'h00, 8'h06, 1'b1, 10'd15);
        add_vec(8'h00, 8'h00, 1'b1, 10'd16);
        add_vec(8'h00, 8'h00, 1'b1, 10'd17);
        add_vec(8'h80, 8'h00, 1'b1, 10'd18);
        add_vec(8'h80, 8'h80, 1'b1, 10'd19);
        add_vec(8'h00, 8'h80, 1'b1, 10'd20);
        add_vec(8'h00, 8'h00, 1'b1, 10'd21);
        add_vec(8'h00, 8'h00, 1'b1, 10'd22);
        add_vec(8'h00, 8'h00, 1'b1, 10'd23);
        add_vec(8'h00, 8'h67, 1'b0, 10'd0);
        add_vec(8'h00, 8'h67, 1'b0, 10'd1);
        for (int i = 0; i < vecs.size(); i++) begin
            bus_if.ui_in = vecs[i].ui;
            frame_pulse();
            check($sformatf("vec%0d_led", i),  {24'd0, bus_if.led},       {24'd0, vecs[i].led});
            check($sformatf("vec%0d_show", i), {31'd0, bus_if.show},      {31'd0, vecs[i].show});
            check($sformatf("vec%0d_fc", i),   {22'd0, bus_if.frame_cnt}, {22'd0, vecs[i].fc});
        end

        // vsync held high: exactly one tick, switch noise meanwhile is ignored.
        @(negedge clk);
        bus_if.vsync = 1'b1;
        ticks = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus_if.frame_tick) ticks++;
            if (c > 2) bus_if.ui_in = 8'($urandom_range(0, 255));
        end
        check("hold_ticks", ticks, 32'd1);
        check("hold_fc",   {22'd0, bus_if.frame_cnt}, 32'd2);
        check("hold_led",  {24'd0, bus_if.led},       32'h67);
        check("hold_show", {31'd0, bus_if.show},      32'd0);
        bus_if.vsync = 1'b0;
        bus_if.ui_in = 8'h55;
        repeat (5) @(negedge clk);
        bus_if.ui_in = 8'h00;
        frame_pulse();
        check("between_fc",   {22'd0, bus_if.frame_cnt}, 32'd3);
        check("between_led",  {24'd0, bus_if.led},       32'h67);
        check("between_show", {31'd0, bus_if.show},      32'd0);

        // Asynchronous reset while LIVE and with frame_tick high.
        bus_if.ui_in = 8'h06;
        frame_pulse();
        frame_pulse();
        check("live_led",  {24'd0, bus_if.led},  32'h06);
        check("live_show", {31'd0, bus_if.show}, 32'd1);
        @(negedge clk);
        bus_if.vsync = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_tick", {31'd0, bus_if.frame_tick}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_led",  {24'd0, bus_if.led},        32'h67);
        check("arst_fc",   {22'd0, bus_if.frame_cnt},  32'd0);
        check("arst_show", {31'd0, bus_if.show},       32'd0);
        check("arst_tick", {31'd0, bus_if.frame_tick}, 32'd0);
        bus_if.vsync = 1'b0;
        bus_if.ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        frame_pulse();
        check("post_rst_fc",   {22'd0, bus_if.frame_cnt}, 32'd1);
        check("post_rst_led",  {24'd0, bus_if.led},       32'h67);
        check("post_rst_show", {31'd0, bus_if.show},      32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
